// File: rtl/prog_loader.sv
// prog_loader: 8N1 UART receiver that writes a DEPTH-byte program into a
// 4-bit-addressed memory after each start pulse.
module prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       start,
  output logic [3:0] addr_out,
  output logic [7:0] data_out,
  output logic       we_out,
  output logic       busy,
  output logic       done,
  output logic       frame_err
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF   = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX   = BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                rx_meta;
  logic                rx_sync;
  logic                rx_prev;
  logic                rx_fall;
  logic [CNT_W-1:0]    clk_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic                cnt_clr_c;
  logic                data_tick_c;
  logic                stop_tick_c;

  // Two-flop synchronizer plus one history flop for start-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // Receive FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Receive FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rx_fall) state_nxt = S_START;
      end
      S_START: begin
        if (clk_cnt == HALF_LAST) state_nxt = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (clk_cnt == BIT_LAST && bit_cnt == BIT_MAX) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (clk_cnt == BIT_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Receive FSM control strobes: counter restart, data sample, stop sample
  always_comb begin
    cnt_clr_c   = 1'b0;
    data_tick_c = 1'b0;
    stop_tick_c = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr_c = 1'b1;
      end
      S_START: begin
        if (clk_cnt == HALF_LAST) cnt_clr_c = 1'b1;
      end
      S_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_clr_c   = 1'b1;
          data_tick_c = 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_clr_c   = 1'b1;
          stop_tick_c = 1'b1;
        end
      end
      default: cnt_clr_c = 1'b1;
    endcase
  end

  // Bit-period counter, data bit counter and LSB-first shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      clk_cnt <= cnt_clr_c ? '0 : clk_cnt + 1'b1;
      if (data_tick_c) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {rx_sync, shreg[DATA_W-1:1]};
      end else if (state != S_DATA) begin
        bit_cnt <= '0;
      end
    end
  end

  // Load control: arming, memory write strobe, write index and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_out  <= '0;
      data_out  <= '0;
      we_out    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      we_out <= 1'b0;
      if (start && !busy) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        frame_err <= 1'b0;
        addr_out  <= '0;
      end else begin
        if (stop_tick_c && busy) begin
          if (rx_sync) begin
            we_out   <= 1'b1;
            data_out <= shreg;
          end else begin
            frame_err <= 1'b1;
          end
        end
        // Advance the index the cycle after a write; the last slot ends the load
        if (we_out) begin
          if (addr_out == IDX_LAST) begin
            addr_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            addr_out <= addr_out + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench with a write scoreboard for prog_loader.
module tb_prog_loader;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       start;
  logic [3:0] addr_out;
  logic [7:0] data_out;
  logic       we_out;
  logic       busy;
  logic       done;
  logic       frame_err;

  int vectors     = 0;
  int miscompares = 0;
  int wr_count    = 0;
  int exp_wr      = 0;

  logic [11:0] sb[$];
  logic [11:0] mon_exp;

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .start     (start),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .we_out    (we_out),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && we_out) begin
      wr_count++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
               addr_out, data_out);
      end else begin
        mon_exp = sb.pop_front();
        chk("wr_addr", 32'(addr_out), 32'(mon_exp[11:8]));
        chk("wr_data", 32'(data_out), 32'(mon_exp[7:0]));
      end
    end
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
    sb.push_back({a, d});
    exp_wr++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_addr", 32'(addr_out), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_we", 32'(we_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);

    // Full back-to-back load of 0x00..0x0F
    pulse_start();
    chk("arm_busy", 32'(busy), 32'h1);
    chk("arm_done", 32'(done), 32'h0);
    for (int i = 0; i < 16; i++) begin
      expect_write(4'(i), 8'(i));
      send_byte(8'(i), 1'b1);
    end
    repeat (4) @(negedge clk);
    chk("full_wr_count", 32'(wr_count), 32'(exp_wr));
    chk("full_done", 32'(done), 32'h1);
    chk("full_busy", 32'(busy), 32'h0);
    chk("full_ferr", 32'(frame_err), 32'h0);
    chk("full_addr_wrap", 32'(addr_out), 32'h0);
    chk("full_data_hold", 32'(data_out), 32'h0f);
    chk("full_sb_empty", 32'(sb.size()), 32'h0);

    // Framing error then a good byte
    pulse_start();
    chk("rearm_busy", 32'(busy), 32'h1);
    chk("rearm_done_clr", 32'(done), 32'h0);
    send_byte(8'ha5, 1'b0);
    chk("ferr_set", 32'(frame_err), 32'h1);
    chk("ferr_no_write", 32'(wr_count), 32'(exp_wr));
    chk("ferr_addr", 32'(addr_out), 32'h0);
    expect_write(4'd0, 8'h3c);
    send_byte(8'h3c, 1'b1);
    repeat (4) @(negedge clk);
    chk("after_ferr_addr", 32'(addr_out), 32'h1);
    chk("after_ferr_data", 32'(data_out), 32'h3c);
    chk("ferr_sticky", 32'(frame_err), 32'h1);

    // One-cycle glitch must not produce a byte
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (5 * CPB) @(negedge clk);
    chk("glitch_no_write", 32'(wr_count), 32'(exp_wr));
    chk("glitch_addr", 32'(addr_out), 32'h1);
    chk("glitch_busy", 32'(busy), 32'h1);
    expect_write(4'd1, 8'h5a);
    send_byte(8'h5a, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_glitch_addr", 32'(addr_out), 32'h2);

    // Start while busy is ignored
    expect_write(4'd2, 8'h11);
    send_byte(8'h11, 1'b1);
    expect_write(4'd3, 8'h22);
    send_byte(8'h22, 1'b1);
    expect_write(4'd4, 8'h33);
    send_byte(8'h33, 1'b1);
    repeat (4) @(negedge clk);
    chk("five_addr", 32'(addr_out), 32'h5);
    pulse_start();
    chk("busy_start_busy", 32'(busy), 32'h1);
    chk("busy_start_addr", 32'(addr_out), 32'h5);
    expect_write(4'd5, 8'hc3);
    send_byte(8'hc3, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_start_next_addr", 32'(addr_out), 32'h6);
    chk("busy_start_wr_count", 32'(wr_count), 32'(exp_wr));

    // Unarmed byte is discarded
    do_reset();
    chk("unarm_busy", 32'(busy), 32'h0);
    send_byte(8'h55, 1'b1);
    repeat (8) @(negedge clk);
    chk("unarm_no_write", 32'(wr_count), 32'(exp_wr));
    chk("unarm_addr", 32'(addr_out), 32'h0);
    chk("unarm_done", 32'(done), 32'h0);
    chk("unarm_ferr", 32'(frame_err), 32'h0);

    // Reset in the 4th data bit aborts the frame
    pulse_start();
    chk("pre_abort_busy", 32'(busy), 32'h1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_we", 32'(we_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    chk("abort_no_write", 32'(wr_count), 32'(exp_wr));
    chk("abort_busy", 32'(busy), 32'h0);
    pulse_start();
    expect_write(4'd0, 8'h81);
    send_byte(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    chk("abort_then_addr", 32'(addr_out), 32'h1);
    chk("abort_then_data", 32'(data_out), 32'h81);
    chk("final_wr_count", 32'(wr_count), 32'(exp_wr));
    chk("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal values are 4 or more.
REQ-002 Parameter DEPTH, default 16, number of bytes per program load (one per 4-bit memory address).
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx  input  1  asynchronous serial line: idle high, 8N1, LSB first.
REQ-006 start  input  1  one-cycle pulse that arms a new program load.
REQ-007 addr_out  output  4  memory write address.
REQ-008 data_out  output  8  memory write data.
REQ-009 we_out  output  1  one-cycle write strobe; addr_out and data_out are valid while it is high.
REQ-010 busy  output  1  high while a load is armed and incomplete.
REQ-011 done  output  1  sticky; high after DEPTH bytes have been written.
REQ-012 frame_err  output  1  sticky; a stop bit was sampled low during the current load.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all rx decisions use the synchronized value.
REQ-014 The receive FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-015 IDLE -> START on a synchronized high-to-low transition of rx.
REQ-016 START SHALL resample rx after CLKS_PER_BIT/2 cycles (integer division): low -> DATA; high -> IDLE (glitch, nothing written).
REQ-017 DATA SHALL sample one bit every CLKS_PER_BIT cycles, LSB first, 8 bits, then go to STOP.
REQ-018 STOP SHALL sample rx CLKS_PER_BIT cycles after the last data bit, then go to IDLE.
REQ-019 Stop bit high while busy -> we_out pulses for exactly one cycle, with data_out = received byte and addr_out = current write index.
REQ-020 The write index SHALL increment the cycle after each write.
REQ-021 Stop bit low while busy -> no write, index unchanged, frame_err set.
REQ-022 Bytes completed while busy=0 SHALL be decoded and discarded: no we_out, no flag changes.
REQ-023 start while busy=0 SHALL, on the next cycle:
  - set busy=1
  - clear done and frame_err
  - set the write index to 0
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 On the cycle after the write to index DEPTH-1: busy=0, done=1, and the index wraps to 0.
REQ-026 The receive FSM SHALL keep running independently of start; a start that lands mid-frame lets that frame complete and write at index 0.
REQ-027 addr_out SHALL equal the write index at all times.
REQ-028 data_out SHALL hold the last received byte between writes.
REQ-029 Write latency: we_out is asserted 1 cycle after the STOP sample.
REQ-030 Back-to-back frames with no idle gap beyond the stop bit SHALL be received without loss.

Reset
REQ-031 rst high SHALL immediately force the following, regardless of clk:
  - FSM = IDLE
  - synchronizer flops = 1
  - addr_out = 0, data_out = 0
  - we_out, busy, done, frame_err = 0
  - bit and cycle counters = 0
REQ-032 rst asserted mid-frame SHALL abort the frame with no write; after release the block waits for a fresh start bit.

Verification
REQ-033 CLKS_PER_BIT=4, DEPTH=16; start, then bytes 0x00..0x0F -> 16 we_out pulses at addr 0..15 with data = addr; then done=1, busy=0, frame_err=0.
REQ-034 Armed; send 0xA5 with stop bit low, then 0x3C -> no write for 0xA5; frame_err=1; 0x3C is written at addr 0.
REQ-035 Armed; 1-cycle low glitch on rx (shorter than CLKS_PER_BIT/2) -> FSM returns to IDLE, no we_out.
REQ-036 Not armed; send 0x55 -> no we_out; addr_out stays 0; done stays 0.
REQ-037 Armed; rst pulse during the 4th data bit of a frame, then start and 0x81 -> only write is 0x81 at addr 0.
REQ-038 Armed with 5 bytes written; pulse start -> ignored: index continues at 5, busy stays 1.
